mem_req_ctrl: RTL and testbench

- Sequences one MEM-stage data access at a time against the data cache's addr_ok/data_ok handshake.
- Registers the request and holds it stable until the cache accepts it.
- Buffers a returned response while the pipeline cannot advance.
- Drops in-flight responses after a pipeline flush, and generates stallreq for the MEM stage.

---
 rtl/mem_req_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_req_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// MEM-stage data-cache request sequencer: one access in flight, holds the request
// stable until addr_ok, buffers a response the pipeline cannot take, drops flushed data.
module mem_req_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      req_valid,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH/8-1:0]   req_sel,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic                      pipe_advance,
    output logic                      cache_req_valid,
    output logic                      cache_we,
    output logic [ADDR_WIDTH-1:0]     cache_addr,
    output logic [DATA_WIDTH/8-1:0]   cache_sel,
    output logic [DATA_WIDTH-1:0]     cache_wdata,
    input  logic                      cache_addr_ok,
    input  logic                      cache_data_ok,
    input  logic [DATA_WIDTH-1:0]     cache_rdata,
    output logic                      resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_data,
    output logic                      stallreq
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ADDR = 3'd1,
        WAIT_DATA = 3'd2,
        HOLD      = 3'd3,
        DISCARD   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic                      discard_q, discard_d;
    logic                      we_q, we_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH/8-1:0]   sel_q, sel_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     buf_q, buf_d;

    logic                      req_v;
    logic                      c_we;
    logic [ADDR_WIDTH-1:0]     c_addr;
    logic [DATA_WIDTH/8-1:0]   c_sel;
    logic [DATA_WIDTH-1:0]     c_wdata;
    logic                      rv;
    logic [DATA_WIDTH-1:0]     rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            sel_q     <= '0;
            wdata_q   <= '0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            buf_q     <= buf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        we_d      = we_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        buf_d     = buf_q;
        req_v     = 1'b0;
        c_we      = we_q;
        c_addr    = addr_q;
        c_sel     = sel_q;
        c_wdata   = wdata_q;
        rv        = 1'b0;
        rd        = '0;

        case (state_q)
            IDLE: begin
                // Zero-cycle issue straight from the MEM-stage inputs
                if (req_valid && !flush) begin
                    req_v     = 1'b1;
                    c_we      = req_we;
                    c_addr    = req_addr;
                    c_sel     = req_sel;
                    c_wdata   = req_wdata;
                    we_d      = req_we;
                    addr_d    = req_addr;
                    sel_d     = req_sel;
                    wdata_d   = req_wdata;
                    discard_d = 1'b0;
                    state_d   = cache_addr_ok ? WAIT_DATA : WAIT_ADDR;
                end
            end
            WAIT_ADDR: begin
                // The cache may already be committed to this request, so it is never withdrawn
                req_v = 1'b1;
                if (flush) discard_d = 1'b1;
                if (cache_addr_ok) state_d = (discard_q || flush) ? DISCARD : WAIT_DATA;
            end
            WAIT_DATA: begin
                if (cache_data_ok) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else if (pipe_advance) begin
                        rv      = 1'b1;
                        rd      = we_q ? '0 : cache_rdata;
                        state_d = IDLE;
                    end else begin
                        buf_d   = we_q ? '0 : cache_rdata;
                        state_d = HOLD;
                    end
                end else if (flush) begin
                    state_d = DISCARD;
                end
            end
            HOLD: begin
                rv = 1'b1;
                rd = buf_q;
                if (flush || pipe_advance) state_d = IDLE;
            end
            DISCARD: begin
                if (cache_data_ok) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced to zero while rst is held, not just after the next edge
    assign cache_req_valid = req_v & ~rst;
    assign cache_we        = cache_req_valid & c_we;
    assign cache_addr      = cache_req_valid ? c_addr  : '0;
    assign cache_sel       = cache_req_valid ? c_sel   : '0;
    assign cache_wdata     = cache_req_valid ? c_wdata : '0;
    assign resp_valid      = rv & ~rst;
    assign resp_data       = resp_valid ? rd : '0;
    assign stallreq        = req_valid & ~resp_valid & ~flush & ~rst;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Testbench for mem_req_ctrl: scenario tasks with inline checks plus a response
// scoreboard that is filled when cache_data_ok is driven and drained on pipe_advance.
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_sel = '0;
    logic [31:0] req_wdata = '0;
    logic        pipe_advance = 1'b0;
    logic        cache_req_valid;
    logic        cache_we;
    logic [31:0] cache_addr;
    logic [3:0]  cache_sel;
    logic [31:0] cache_wdata;
    logic        cache_addr_ok = 1'b0;
    logic        cache_data_ok = 1'b0;
    logic [31:0] cache_rdata = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        stallreq;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    mem_req_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_sel(req_sel), .req_wdata(req_wdata), .pipe_advance(pipe_advance),
        .cache_req_valid(cache_req_valid), .cache_we(cache_we), .cache_addr(cache_addr),
        .cache_sel(cache_sel), .cache_wdata(cache_wdata),
        .cache_addr_ok(cache_addr_ok), .cache_data_ok(cache_data_ok), .cache_rdata(cache_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    // Scoreboard: every visible response must match the oldest expected one
    always @(negedge clk) begin
        if (resp_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected got resp_data=%h want no response", resp_data);
            end else begin
                if (resp_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL sb_data got %h want %h", resp_data, exp_q[0]);
                end
                if (pipe_advance) begin
                    $display("[TB] response %h consumed", exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; req_valid = 0; req_we = 0; req_addr = '0; req_sel = '0; req_wdata = '0;
        pipe_advance = 0; cache_addr_ok = 0; cache_data_ok = 0; cache_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 1; req_addr = 32'h0000_0abc; req_sel = 4'hf;
        tick();
        @(negedge clk);
        n_tests++; if (cache_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b want 0", cache_req_valid); end
        n_tests++; if (cache_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", cache_addr); end
        n_tests++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stallreq got %b want 0", stallreq); end
        n_tests++; if (resp_valid !== 1'b0 || resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_resp got %b/%h want 0/0", resp_valid, resp_data); end
        $display("[TB] reset checked");
        tick();
        rst = 0; clear_inputs();
        tick();
    endtask

    task automatic test_load();
        req_valid = 1; req_we = 0; req_addr = 32'h1000; req_sel = 4'hf; cache_addr_ok = 1;
        @(negedge clk);
        n_tests++; if (cache_req_valid !== 1'b1 || cache_addr !== 32'h1000 || cache_we !== 1'b0) begin n_fail++; $display("FAIL load_issue got v=%b a=%h we=%b want 1/00001000/0", cache_req_valid, cache_addr, cache_we); end
        n_tests++; if (stallreq !== 1'b1) begin n_fail++; $display("FAIL load_stall_c0 got %b want 1", stallreq); end
        tick();
        cache_addr_ok = 0;
        @(negedge clk);
        n_tests++; if (cache_req_valid !== 1'b0 || stallreq !== 1'b1) begin n_fail++; $display("FAIL load_wait got v=%b stall=%b want 0/1", cache_req_valid, stallreq); end
        tick();
        cache_data_ok = 1; cache_rdata = 32'hDEADBEEF; pipe_advance = 1; exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1 || stallreq !== 1'b0) begin n_fail++; $display("FAIL load_done got rv=%b stall=%b want 1/0", resp_valid, stallreq); end
        tick();
        clear_inputs();
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b0 || cache_req_valid !== 1'b0) begin n_fail++; $display("FAIL load_after got rv=%b v=%b want 0/0", resp_valid, cache_req_valid); end
        $display("[TB] load 00001000 done");
        tick();
    endtask

    task automatic test_store();
        req_valid = 1; req_we = 1; req_addr = 32'h2004; req_sel = 4'hf; req_wdata = 32'h12345678;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin req_addr = 32'hFFFF0000; req_wdata = 32'h0BAD0BAD; req_sel = 4'h1; end
            if (c == 3) cache_addr_ok = 1;
            @(negedge clk);
            n_tests++; if (cache_req_valid !== 1'b1 || cache_addr !== 32'h2004 || cache_wdata !== 32'h12345678 || cache_we !== 1'b1 || cache_sel !== 4'hf)
                begin n_fail++; $display("FAIL store_hold c%0d got v=%b a=%h d=%h we=%b sel=%h want 1/00002004/12345678/1/f", c, cache_req_valid, cache_addr, cache_wdata, cache_we, cache_sel); end
            tick();
        end
        cache_addr_ok = 0;
        @(negedge clk);
        n_tests++; if (cache_req_valid !== 1'b0) begin n_fail++; $display("FAIL store_wait got %b want 0", cache_req_valid); end
        tick();
        cache_data_ok = 1; cache_rdata = 32'h99999999; pipe_advance = 1; exp_q.push_back(32'h0);
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1 || resp_data !== 32'h0) begin n_fail++; $display("FAIL store_done got rv=%b d=%h want 1/0", resp_valid, resp_data); end
        $display("[TB] store 00002004 done");
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_hold();
        req_valid = 1; req_addr = 32'h1100; req_sel = 4'hf; cache_addr_ok = 1;
        tick();
        cache_addr_ok = 0; cache_data_ok = 1; cache_rdata = 32'hA5A5A5A5; pipe_advance = 0;
        exp_q.push_back(32'hA5A5A5A5);
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b0 || stallreq !== 1'b1) begin n_fail++; $display("FAIL hold_latch got rv=%b stall=%b want 0/1", resp_valid, stallreq); end
        tick();
        cache_data_ok = 0; cache_rdata = 32'h0;
        for (int c = 0; c < 3; c++) begin
            pipe_advance = (c == 2);
            @(negedge clk);
            n_tests++; if (resp_valid !== 1'b1 || resp_data !== 32'hA5A5A5A5 || stallreq !== 1'b0)
                begin n_fail++; $display("FAIL hold_c%0d got rv=%b d=%h stall=%b want 1/a5a5a5a5/0", c, resp_valid, resp_data, stallreq); end
            tick();
        end
        req_valid = 0; pipe_advance = 0;
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got %b want 0", resp_valid); end
        $display("[TB] hold a5a5a5a5 done");
        tick();
    endtask

    task automatic test_flush_wait_addr();
        req_valid = 1; req_addr = 32'h1200; req_sel = 4'hf;
        tick();
        flush = 1; req_addr = 32'h1300;
        @(negedge clk);
        n_tests++; if (cache_req_valid !== 1'b1 || cache_addr !== 32'h1200 || stallreq !== 1'b0) begin n_fail++; $display("FAIL fwa_flush got v=%b a=%h stall=%b want 1/00001200/0", cache_req_valid, cache_addr, stallreq); end
        tick();
        flush = 0; cache_addr_ok = 1;
        @(negedge clk);
        n_tests++; if (cache_req_valid !== 1'b1 || cache_addr !== 32'h1200) begin n_fail++; $display("FAIL fwa_keep got v=%b a=%h want 1/00001200", cache_req_valid, cache_addr); end
        tick();
        cache_addr_ok = 0;
        @(negedge clk);
        n_tests++; if (cache_req_valid !== 1'b0 || stallreq !== 1'b1) begin n_fail++; $display("FAIL fwa_discard got v=%b stall=%b want 0/1", cache_req_valid, stallreq); end
        tick();
        cache_data_ok = 1; cache_rdata = 32'h5555;
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b0 || cache_req_valid !== 1'b0) begin n_fail++; $display("FAIL fwa_drop got rv=%b v=%b want 0/0", resp_valid, cache_req_valid); end
        tick();
        cache_data_ok = 0; cache_addr_ok = 1;
        @(negedge clk);
        n_tests++; if (cache_req_valid !== 1'b1 || cache_addr !== 32'h1300) begin n_fail++; $display("FAIL fwa_reissue got v=%b a=%h want 1/00001300", cache_req_valid, cache_addr); end
        tick();
        cache_addr_ok = 0; cache_data_ok = 1; cache_rdata = 32'h13001300; pipe_advance = 1;
        exp_q.push_back(32'h13001300);
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL fwa_next_done got %b want 1", resp_valid); end
        $display("[TB] flush in WAIT_ADDR done");
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_flush_data();
        req_valid = 1; req_addr = 32'h1400; req_sel = 4'hf; cache_addr_ok = 1;
        tick();
        cache_addr_ok = 0; cache_data_ok = 1; cache_rdata = 32'h77777777; flush = 1; pipe_advance = 1;
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b0 || stallreq !== 1'b0) begin n_fail++; $display("FAIL fd_drop got rv=%b stall=%b want 0/0", resp_valid, stallreq); end
        tick();
        flush = 0; cache_data_ok = 0; pipe_advance = 0; req_addr = 32'h3000; cache_addr_ok = 1;
        @(negedge clk);
        n_tests++; if (cache_req_valid !== 1'b1 || cache_addr !== 32'h3000) begin n_fail++; $display("FAIL fd_next_issue got v=%b a=%h want 1/00003000", cache_req_valid, cache_addr); end
        tick();
        cache_addr_ok = 0; cache_data_ok = 1; cache_rdata = 32'h30003000; pipe_advance = 1;
        exp_q.push_back(32'h30003000);
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL fd_next_done got %b want 1", resp_valid); end
        $display("[TB] flush with data_ok done");
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        req_valid = 1; req_addr = 32'h1500; req_sel = 4'hf; cache_addr_ok = 1;
        tick();
        cache_addr_ok = 0;
        @(negedge clk);
        n_tests++; if (cache_req_valid !== 1'b0 || stallreq !== 1'b1) begin n_fail++; $display("FAIL ar_wait got v=%b stall=%b want 0/1", cache_req_valid, stallreq); end
        #2 rst = 1;
        #1;
        n_tests++; if (cache_req_valid !== 1'b0 || stallreq !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 32'h0 || cache_addr !== 32'h0)
            begin n_fail++; $display("FAIL ar_outputs got v=%b stall=%b rv=%b d=%h a=%h want all 0", cache_req_valid, stallreq, resp_valid, resp_data, cache_addr); end
        tick();
        rst = 0; req_addr = 32'h4000; cache_addr_ok = 1;
        @(negedge clk);
        n_tests++; if (cache_req_valid !== 1'b1 || cache_addr !== 32'h4000) begin n_fail++; $display("FAIL ar_issue got v=%b a=%h want 1/00004000", cache_req_valid, cache_addr); end
        tick();
        cache_addr_ok = 0; cache_data_ok = 1; cache_rdata = 32'h40004000; pipe_advance = 1;
        exp_q.push_back(32'h40004000);
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL ar_done got %b want 1", resp_valid); end
        $display("[TB] async reset done");
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] d;
        req_valid = 1; req_sel = 4'hf; pipe_advance = 1;
        for (int i = 0; i < 4; i++) begin
            a = 32'h5000 + 32'(i) * 4;
            d = $urandom;
            req_addr = a; cache_addr_ok = 1; cache_data_ok = 0;
            @(negedge clk);
            n_tests++; if (cache_req_valid !== 1'b1 || cache_addr !== a) begin n_fail++; $display("FAIL b2b_issue%0d got v=%b a=%h want 1/%h", i, cache_req_valid, cache_addr, a); end
            tick();
            cache_addr_ok = 0; cache_data_ok = 1; cache_rdata = d; exp_q.push_back(d);
            @(negedge clk);
            n_tests++; if (cache_req_valid !== 1'b0 || resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_done%0d got v=%b rv=%b want 0/1", i, cache_req_valid, resp_valid); end
            tick();
        end
        clear_inputs();
        cache_data_ok = 1; cache_rdata = 32'hCAFECAFE;
        @(negedge clk);
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_data_ok got %b want 0", resp_valid); end
        $display("[TB] back-to-back done");
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        #1;
        test_reset();
        test_load();
        test_store();
        test_hold();
        test_flush_wait_addr();
        test_flush_data();
        test_async_reset();
        test_back_to_back();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got %0d pending want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
